mult_fu_pipe: RTL and testbench
===============================

// Module: mult_fu_pipe
// PURPOSE
//  Pipelined integer multiply functional unit for RV32M MUL/MULH/MULHSU/MULHU. It sits directly upstream of the
//  completion arbiter, occupying one fu_finish/fu_c_stall slot and one FU_COMPLETE_PACKET lane. It raises
//  fu_finish when a result is ready, holds that result while the arbiter stalls it, and presents the packet the
//  cycle after it is granted. Squash flushes every in-flight op.
// PARAMETERS
//  STAGES   4       pipeline depth; legal values 1,2,4,8; each stage retires 2*XLEN/STAGES multiplier bits
// PORTS
//  clock            in   1          single clock, rising edge
//  reset            in   1          asynchronous, active-low: all state clears immediately while reset==0
//  squash           in   1          synchronous flush (branch mispredict / precise-state recovery)
//  issue_valid      in   1          issue request this cycle
//  issue_opa        in   XLEN       rs1 value
//  issue_opb        in   XLEN       rs2 value
//  issue_func       in   2          MULT_FUNC: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  issue_dest_pr    in   `PR        destination physical register
//  issue_rob_entry  in   `ROB       ROB index
//  issue_ready      out  1          op accepted at this edge if issue_valid && issue_ready
//  fu_finish        out  1          this FU's bit in the arbiter's FU_STATE_PACKET
//  fu_c_stall       in   1          this FU's stall bit from the arbiter; same-cycle function of fu_finish
//  fu_c_out         out  FU_COMPLETE_PACKET  {dest_pr, dest_value, rob_entry, if_take_branch=0, target_pc=0}
// BEHAVIOUR
//  Reset: all stage valids 0, issue_ready=1, fu_finish=0, fu_c_out all-zero.
//  Operands: extend to 2*XLEN. opa is signed for MULH/MULHSU. opb is signed for MULH only.
//   Product is taken mod 2^(2*XLEN). MUL returns P[XLEN-1:0]; all others return P[2*XLEN-1:XLEN].
//  Stage k holds {valid, func, dest_pr, rob_entry, mcand, remaining multiplier, partial sum}.
//   Each advance adds the partial products of the next 2*XLEN/STAGES multiplier bits.
//  Timing, no stall: issue accepted at the end of cycle 0; op in stage k during cycle k+1.
//   fu_finish=1 in cycle STAGES (last stage valid).
//   If fu_c_stall=0 that cycle, fu_c_out carries the packet in cycle STAGES+1, for exactly one cycle.
//   fu_c_out is all-zero in every other cycle.
//  Stall: last stage valid && fu_c_stall=1 -> last stage holds; fu_finish stays 1 next cycle.
//   Stage k advances iff stage k+1 is empty or advancing (bubble collapse).
//   issue_ready = !stage0.valid || stage0 advancing (combinational).
//   Back-to-back ops give one result per cycle with no stall.
//  Grant: fu_finish && !fu_c_stall moves the last stage into the output register.
//  Squash: at the next edge all stage valids and the output register clear.
//   An issue in the squash cycle is dropped; fu_finish is forced 0 during squash.
//   An output-register packet already showing in the squash cycle completes (it was granted earlier).
//  Reset mid-operation: immediate clear; no partial packet may appear after reset deasserts.
//  Simultaneous: grant + issue into the freed pipeline in the same cycle is legal. A stall with a full pipe
//   deasserts issue_ready. if_take_branch and target_pc are always 0.
// STRUCTURE
//  sys_defs package: MULT_FUNC enum, FU_COMPLETE_PACKET, XLEN/PR/ROB widths, MULT_STAGE_PACKET typedef.
//  Sub-module mult_stage: combinational partial-product accumulate of one multiplier chunk. Instantiated STAGES
//   times between the stage registers. The top level owns the valid/stall/squash control and the output register.
// TESTING
//  1 MUL 7*6, no stall -> fu_finish cycle 4; fu_c_out.dest_value=42 cycle 5 with issue dest_pr/rob_entry.
//  2 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x0; MULHU same -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF;
//    MUL 0x80000000*2 -> 0x0.
//  3 Four back-to-back issues, fu_c_stall=1 cycles 4-6 -> fu_finish held; issue_ready=0 once 4 stages full;
//    results in order cycles 8-11, none lost or duplicated.
//  4 Stall with one op in stage 3 and a bubble in stage 2 -> stage 1 op moves to stage 2; issue_ready stays 1.
//  5 squash with 3 ops in flight plus a same-cycle issue -> no fu_finish or packet from any of them;
//    a later op completes normally.
//  6 reset=0 mid-pipeline -> all outputs zero immediately; after release, a first op completes at its nominal latency.

Source files
------------

// File: rtl/mult_fu_pipe_pkg.sv
// Shared types for the pipelined RV32M multiply unit: function codes,
// completion packet, and the per-stage pipeline payload.
package mult_fu_pipe_pkg;

  localparam int XLEN  = 32;
  localparam int PR_W  = 6;
  localparam int ROB_W = 5;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'b00,
    MULT_MULH   = 2'b01,
    MULT_MULHSU = 2'b10,
    MULT_MULHU  = 2'b11
  } mult_func_e;

  typedef struct packed {
    logic [PR_W-1:0]  dest_pr;
    logic [XLEN-1:0]  dest_value;
    logic [ROB_W-1:0] rob_entry;
    logic             if_take_branch;
    logic [XLEN-1:0]  target_pc;
  } fu_complete_packet_t;

  typedef struct packed {
    mult_func_e        func;
    logic [PR_W-1:0]   dest_pr;
    logic [ROB_W-1:0]  rob_entry;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] mplier;
    logic [2*XLEN-1:0] sum;
  } mult_stage_packet_t;

  // Widen an operand to 2*XLEN; sign-extension makes the modular product exact.
  function automatic logic [2*XLEN-1:0] extend_op(input logic [XLEN-1:0] v, input logic sgn);
    logic signed [XLEN-1:0] sv;
    sv = signed'(v);
    return sgn ? {{XLEN{sv[XLEN-1]}}, v} : {{XLEN{1'b0}}, v};
  endfunction

endpackage

// File: rtl/mult_fu_pipe_stage.sv
// One multiplier step: accumulates the partial product of the next CHUNK
// multiplier bits and shifts the operands for the following stage.
module mult_fu_pipe_stage
  import mult_fu_pipe_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  mult_stage_packet_t in_pkt,
  output mult_stage_packet_t out_pkt
);

  logic [2*XLEN-1:0] chunk_ext;

  always_comb begin
    chunk_ext                = '0;
    chunk_ext[CHUNK-1:0]     = in_pkt.mplier[CHUNK-1:0];
    out_pkt                  = in_pkt;
    out_pkt.sum              = in_pkt.sum + (in_pkt.mcand * chunk_ext);
    out_pkt.mcand            = in_pkt.mcand << CHUNK;
    out_pkt.mplier           = in_pkt.mplier >> CHUNK;
  end

endmodule

// File: rtl/mult_fu_pipe.sv
// Pipelined RV32M multiply functional unit with bubble-collapsing stall
// control, squash flush and a one-cycle completion output register.
module mult_fu_pipe
  import mult_fu_pipe_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                squash,
  input  logic                issue_valid,
  input  logic [XLEN-1:0]     issue_opa,
  input  logic [XLEN-1:0]     issue_opb,
  input  logic [1:0]          issue_func,
  input  logic [PR_W-1:0]     issue_dest_pr,
  input  logic [ROB_W-1:0]    issue_rob_entry,
  output logic                issue_ready,
  output logic                fu_finish,
  input  logic                fu_c_stall,
  output fu_complete_packet_t fu_c_out
);

  localparam int CHUNK = (2 * XLEN) / STAGES;
  localparam int LAST  = STAGES - 1;

  logic [STAGES-1:0]   vld_p;
  logic [STAGES-1:0]   load;
  logic [STAGES-1:0]   adv;
  logic                grant;
  logic                ld_chain;
  mult_stage_packet_t  issue_pkt;
  mult_stage_packet_t  stage_p   [STAGES];
  mult_stage_packet_t  stage_out [STAGES];
  fu_complete_packet_t result_pkt;
  fu_complete_packet_t out_q;

  function automatic logic [XLEN-1:0] select_result(input mult_func_e f,
                                                    input logic [2*XLEN-1:0] p);
    return (f == MULT_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    issue_pkt           = '0;
    issue_pkt.func      = mult_func_e'(issue_func);
    issue_pkt.dest_pr   = issue_dest_pr;
    issue_pkt.rob_entry = issue_rob_entry;
    issue_pkt.mcand     = extend_op(issue_opa, (issue_pkt.func == MULT_MULH) ||
                                               (issue_pkt.func == MULT_MULHSU));
    issue_pkt.mplier    = extend_op(issue_opb, issue_pkt.func == MULT_MULH);
  end

  // Stall control walks from the tail: a stage moves only if its successor can take it.
  always_comb begin
    fu_finish = vld_p[LAST] && !squash;
    grant     = fu_finish && !fu_c_stall;
    adv       = '0;
    load      = '0;
    ld_chain  = 1'b0;
    for (int k = LAST; k >= 0; k--) begin
      if (k == LAST) adv[k] = grant;
      else           adv[k] = vld_p[k] && ld_chain;
      load[k]  = !vld_p[k] || adv[k];
      ld_chain = load[k];
    end
    issue_ready = load[0];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      mult_fu_pipe_stage #(.CHUNK(CHUNK)) u_stage (
        .in_pkt  (issue_pkt),
        .out_pkt (stage_out[k])
      );
    end else begin : g_rest
      mult_fu_pipe_stage #(.CHUNK(CHUNK)) u_stage (
        .in_pkt  (stage_p[k-1]),
        .out_pkt (stage_out[k])
      );
    end
  end

  // Stage registers: payload is only meaningful when the matching vld_p bit is set.
  always_ff @(posedge clock) begin
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) stage_p[k] <= stage_out[k];
    end
  end

  always_comb begin
    result_pkt                = '0;
    result_pkt.dest_pr        = stage_p[LAST].dest_pr;
    result_pkt.dest_value     = select_result(stage_p[LAST].func, stage_p[LAST].sum);
    result_pkt.rob_entry      = stage_p[LAST].rob_entry;
    result_pkt.if_take_branch = 1'b0;
    result_pkt.target_pc      = '0;
  end

  // Completion boundary: the granted packet shows for exactly one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p <= '0;
      out_q <= '0;
    end else if (squash) begin
      vld_p <= '0;
      out_q <= '0;
    end else begin
      if (load[0]) vld_p[0] <= issue_valid;
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) vld_p[k] <= vld_p[k-1];
      end
      out_q <= grant ? result_pkt : '0;
    end
  end

  assign fu_c_out = out_q;

endmodule

// File: tb/tb_mult_fu_pipe.sv
// Directed-vector bench for mult_fu_pipe (STAGES=4): latency, arithmetic,
// stall/bubble behaviour, squash and asynchronous reset.
module tb_mult_fu_pipe;
  import mult_fu_pipe_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic                squash = 1'b0;
  logic                issue_valid = 1'b0;
  logic [XLEN-1:0]     issue_opa = '0;
  logic [XLEN-1:0]     issue_opb = '0;
  logic [1:0]          issue_func = 2'b00;
  logic [PR_W-1:0]     issue_dest_pr = '0;
  logic [ROB_W-1:0]    issue_rob_entry = '0;
  logic                issue_ready;
  logic                fu_finish;
  logic                fu_c_stall = 1'b0;
  fu_complete_packet_t fu_c_out;

  int vectors = 0;
  int miscompares = 0;

  mult_fu_pipe #(.STAGES(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .squash          (squash),
    .issue_valid     (issue_valid),
    .issue_opa       (issue_opa),
    .issue_opb       (issue_opb),
    .issue_func      (issue_func),
    .issue_dest_pr   (issue_dest_pr),
    .issue_rob_entry (issue_rob_entry),
    .issue_ready     (issue_ready),
    .fu_finish       (fu_finish),
    .fu_c_stall      (fu_c_stall),
    .fu_c_out        (fu_c_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_issue(input logic [1:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             input logic [PR_W-1:0] pr, input logic [ROB_W-1:0] rob);
    issue_valid     = 1'b1;
    issue_func      = f;
    issue_opa       = a;
    issue_opb       = b;
    issue_dest_pr   = pr;
    issue_rob_entry = rob;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  function automatic fu_complete_packet_t exp_pkt(input logic [PR_W-1:0] pr, input logic [XLEN-1:0] v,
                                                  input logic [ROB_W-1:0] rob);
    exp_pkt = '{dest_pr: pr, dest_value: v, rob_entry: rob, if_take_branch: 1'b0, target_pc: '0};
  endfunction

  task automatic test_reset();
    step(); step();
    settle();
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", issue_ready); end
    vectors++; if (fu_finish !== 1'b0) begin miscompares++; $display("FAIL rst_finish got %b want 0", fu_finish); end
    vectors++; if (fu_c_out !== '0) begin miscompares++; $display("FAIL rst_out got %h want 0", fu_c_out); end
    reset = 1'b1;
    step(); settle();
    vectors++; if (fu_finish !== 1'b0 || fu_c_out !== '0) begin
      miscompares++; $display("FAIL rst_release got fin=%b out=%h want 0/0", fu_finish, fu_c_out); end
  endtask

  task automatic test_mul_basic();
    fu_complete_packet_t e;
    e = exp_pkt(6'd5, 32'd42, 5'd3);
    step();
    drive_issue(2'b00, 32'd7, 32'd6, 6'd5, 5'd3);
    settle();
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready got %b want 1", issue_ready); end
    step(); idle();
    for (int c = 1; c <= 3; c++) begin
      settle();
      vectors++; if (fu_finish !== 1'b0 || fu_c_out !== '0) begin
        miscompares++; $display("FAIL basic_early c%0d fin=%b out=%h want 0/0", c, fu_finish, fu_c_out); end
      step();
    end
    settle();
    vectors++; if (fu_finish !== 1'b1) begin miscompares++; $display("FAIL basic_finish c4 got %b want 1", fu_finish); end
    step(); settle();
    vectors++; if (fu_c_out !== e) begin miscompares++; $display("FAIL basic_out c5 got %h want %h", fu_c_out, e); end
    step(); settle();
    vectors++; if (fu_c_out !== '0 || fu_finish !== 1'b0) begin
      miscompares++; $display("FAIL basic_after c6 fin=%b out=%h want 0/0", fu_finish, fu_c_out); end
  endtask

  task automatic test_arith();
    logic [1:0]      f_tab [8];
    logic [XLEN-1:0] a_tab [8];
    logic [XLEN-1:0] b_tab [8];
    logic [XLEN-1:0] r_tab [8];
    int n;
    f_tab[0] = 2'b01; a_tab[0] = 32'hFFFFFFFF; b_tab[0] = 32'hFFFFFFFF; r_tab[0] = 32'h00000000;
    f_tab[1] = 2'b11; a_tab[1] = 32'hFFFFFFFF; b_tab[1] = 32'hFFFFFFFF; r_tab[1] = 32'hFFFFFFFE;
    f_tab[2] = 2'b10; a_tab[2] = 32'hFFFFFFFF; b_tab[2] = 32'h00000002; r_tab[2] = 32'hFFFFFFFF;
    f_tab[3] = 2'b00; a_tab[3] = 32'h80000000; b_tab[3] = 32'h00000002; r_tab[3] = 32'h00000000;
    f_tab[4] = 2'b01; a_tab[4] = 32'h80000000; b_tab[4] = 32'h80000000; r_tab[4] = 32'h40000000;
    f_tab[5] = 2'b00; a_tab[5] = 32'h12345678; b_tab[5] = 32'h00000010; r_tab[5] = 32'h23456780;
    f_tab[6] = 2'b01; a_tab[6] = 32'hFFFFFFFE; b_tab[6] = 32'h00000003; r_tab[6] = 32'hFFFFFFFF;
    f_tab[7] = 2'b11; a_tab[7] = 32'h80000000; b_tab[7] = 32'h00000004; r_tab[7] = 32'h00000002;
    for (int i = 0; i < 8; i++) begin
      step();
      drive_issue(f_tab[i], a_tab[i], b_tab[i], PR_W'(i + 1), ROB_W'(i));
      step(); idle();
      settle();
      n = 0;
      while (fu_finish !== 1'b1 && n < 20) begin step(); settle(); n++; end
      vectors++;
      if (n >= 20) begin
        miscompares++; $display("FAIL arith%0d timeout got fin=%b want 1", i, fu_finish);
      end else begin
        step(); settle();
        if (fu_c_out.dest_value !== r_tab[i] || fu_c_out.dest_pr !== PR_W'(i + 1)) begin
          miscompares++;
          $display("FAIL arith%0d got val=%h pr=%0d want val=%h pr=%0d", i, fu_c_out.dest_value,
                   fu_c_out.dest_pr, r_tab[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    fu_complete_packet_t e;
    step();
    for (int i = 0; i < 4; i++) begin
      drive_issue(2'b00, XLEN'(i + 1), 32'd100, PR_W'(10 + i), ROB_W'(i));
      settle();
      vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready c%0d got %b want 1", i, issue_ready); end
      step();
    end
    idle();
    for (int c = 4; c <= 6; c++) begin
      fu_c_stall = 1'b1;
      settle();
      vectors++; if (fu_finish !== 1'b1) begin miscompares++; $display("FAIL b2b_hold c%0d got %b want 1", c, fu_finish); end
      if (c == 4) begin
        vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_full got %b want 0", issue_ready); end
      end
      step();
    end
    fu_c_stall = 1'b0;
    settle();
    vectors++; if (fu_finish !== 1'b1) begin miscompares++; $display("FAIL b2b_grant c7 got %b want 1", fu_finish); end
    step();
    for (int j = 0; j < 4; j++) begin
      e = exp_pkt(PR_W'(10 + j), XLEN'((j + 1) * 100), ROB_W'(j));
      settle();
      vectors++; if (fu_c_out !== e) begin miscompares++; $display("FAIL b2b_out c%0d got %h want %h", 8 + j, fu_c_out, e); end
      step();
    end
    settle();
    vectors++; if (fu_c_out !== '0 || fu_finish !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain fin=%b out=%h want 0/0", fu_finish, fu_c_out); end
  endtask

  task automatic test_stall_bubble();
    fu_complete_packet_t ea, eb;
    ea = exp_pkt(6'd20, 32'd15, 5'd1);
    eb = exp_pkt(6'd21, 32'd20, 5'd2);
    step();
    drive_issue(2'b00, 32'd3, 32'd5, 6'd20, 5'd1); step();
    idle(); step();
    drive_issue(2'b00, 32'd4, 32'd5, 6'd21, 5'd2); step();
    idle(); step();
    fu_c_stall = 1'b1; settle();
    vectors++; if (fu_finish !== 1'b1 || issue_ready !== 1'b1) begin
      miscompares++; $display("FAIL bub_c4 fin=%b rdy=%b want 1/1", fu_finish, issue_ready); end
    step(); settle();
    vectors++; if (issue_ready !== 1'b1 || fu_c_out !== '0) begin
      miscompares++; $display("FAIL bub_c5 rdy=%b out=%h want 1/0", issue_ready, fu_c_out); end
    step();
    fu_c_stall = 1'b0; settle();
    vectors++; if (fu_finish !== 1'b1) begin miscompares++; $display("FAIL bub_c6 fin got %b want 1", fu_finish); end
    step(); settle();
    vectors++; if (fu_c_out !== ea || fu_finish !== 1'b1) begin
      miscompares++; $display("FAIL bub_c7 out=%h fin=%b want %h/1", fu_c_out, fu_finish, ea); end
    step(); settle();
    vectors++; if (fu_c_out !== eb) begin miscompares++; $display("FAIL bub_c8 got %h want %h", fu_c_out, eb); end
    step(); settle();
    vectors++; if (fu_c_out !== '0) begin miscompares++; $display("FAIL bub_c9 got %h want 0", fu_c_out); end
  endtask

  task automatic test_squash();
    fu_complete_packet_t e;
    e = exp_pkt(6'd40, 32'd81, 5'd7);
    step();
    for (int i = 0; i < 3; i++) begin
      drive_issue(2'b00, XLEN'(i + 2), 32'd3, PR_W'(30 + i), ROB_W'(i)); step();
    end
    idle(); step();
    squash = 1'b1;
    drive_issue(2'b00, 32'd5, 32'd5, 6'd33, 5'd3);
    settle();
    vectors++; if (fu_finish !== 1'b0) begin miscompares++; $display("FAIL sq_force got %b want 0", fu_finish); end
    step();
    squash = 1'b0; idle();
    for (int c = 0; c < 6; c++) begin
      settle();
      vectors++; if (fu_finish !== 1'b0 || fu_c_out !== '0) begin
        miscompares++; $display("FAIL sq_flush %0d fin=%b out=%h want 0/0", c, fu_finish, fu_c_out); end
      step();
    end
    drive_issue(2'b00, 32'd9, 32'd9, 6'd40, 5'd7); step();
    idle(); step(); step(); step();
    settle();
    vectors++; if (fu_finish !== 1'b1) begin miscompares++; $display("FAIL sq_after_fin got %b want 1", fu_finish); end
    step(); settle();
    vectors++; if (fu_c_out !== e) begin miscompares++; $display("FAIL sq_after_out got %h want %h", fu_c_out, e); end
  endtask

  task automatic test_reset_mid();
    fu_complete_packet_t e0, e2;
    e0 = exp_pkt(6'd50, 32'd6, 5'd4);
    e2 = exp_pkt(6'd52, 32'd35, 5'd6);
    step();
    drive_issue(2'b00, 32'd2, 32'd3, 6'd50, 5'd4); step();
    drive_issue(2'b00, 32'd2, 32'd4, 6'd51, 5'd5); step();
    idle(); step(); step(); step();
    settle();
    vectors++; if (fu_c_out !== e0) begin miscompares++; $display("FAIL rm_pre got %h want %h", fu_c_out, e0); end
    #1 reset = 1'b0;
    #1;
    vectors++; if (fu_c_out !== '0 || fu_finish !== 1'b0 || issue_ready !== 1'b1) begin
      miscompares++; $display("FAIL rm_clear out=%h fin=%b rdy=%b want 0/0/1", fu_c_out, fu_finish, issue_ready); end
    step();
    #2 reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(); settle();
      vectors++; if (fu_finish !== 1'b0 || fu_c_out !== '0) begin
        miscompares++; $display("FAIL rm_quiet %0d fin=%b out=%h want 0/0", c, fu_finish, fu_c_out); end
    end
    step();
    drive_issue(2'b00, 32'd5, 32'd7, 6'd52, 5'd6); step();
    idle(); step(); step(); step();
    settle();
    vectors++; if (fu_finish !== 1'b1) begin miscompares++; $display("FAIL rm_fin got %b want 1", fu_finish); end
    step(); settle();
    vectors++; if (fu_c_out !== e2) begin miscompares++; $display("FAIL rm_out got %h want %h", fu_c_out, e2); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_arith();
    test_back_to_back();
    test_stall_bubble();
    test_squash();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
